// File: rtl/mpu_host_issuer.sv
// mpu_host_issuer
//   Buffers 8-bit host instructions in a small FIFO and issues them one at a
//   time to the matrix controller, tracking its busy handshake.  LOAD and
//   UNLOAD commands strobe load_rd / unload_wr once per busy cycle, up to
//   WORDS times.  A missing busy response (TIMEOUT cycles) or a short
//   LOAD/UNLOAD transfer raises the sticky err flag.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   host command handshake, cmd_data = {DD, AA, op}
//   busy              controller busy flag
//   host_instruction  instruction to controller, non-zero only during issue
//   load_rd           pop one word from load staging (LOAD in EXEC)
//   unload_wr         capture one controller output word (UNLOAD in EXEC)
//   done              one-cycle completion pulse
//   err / err_clr     sticky error flag and its clear
//   cur_op            op nibble of the command in flight / last issued
module mpu_host_issuer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WORDS      = 64,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       busy,
  output logic [7:0] host_instruction,
  output logic       load_rd,
  output logic       unload_wr,
  output logic       done,
  output logic       err,
  output logic [3:0] cur_op,
  input  logic       err_clr
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(WORDS + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WORDS_C  = WW'(WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_EXEC,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cur_op_q;
  logic [7:0]    host_q;
  logic          done_q;
  logic          err_q;
  logic [TW-1:0] tmo_q;
  logic [WW-1:0] wcnt_q;

  logic       full, empty, push, pop, start, head_nop;
  logic [7:0] head;
  logic       is_load, is_unload, words_left;
  logic       tmo_hit, exec_exit, err_set;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  // Only op codes with bit 2 set are defined commands; everything else is NOP.
  assign head_nop = ~head[2];
  assign push     = cmd_valid & ~full;
  // NOPs drain regardless of busy; real commands wait for an idle controller.
  assign pop      = (state_q == S_IDLE) & ~empty & (head_nop | ~busy);
  assign start    = pop & ~head_nop;

  assign is_load    = (cur_op_q == OP_LOAD);
  assign is_unload  = (cur_op_q == OP_UNLOAD);
  assign words_left = (wcnt_q != WORDS_C);

  assign tmo_hit   = (state_q == S_WAIT_BUSY) & ~busy & (tmo_q == TMO_LAST);
  assign exec_exit = (state_q == S_EXEC) & ~busy;
  assign err_set   = tmo_hit | (exec_exit & (is_load | is_unload) & words_left);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cmd_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_op_q <= '0;
      host_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      host_q <= '0;
      done_q <= 1'b0;
      // A new error wins over a simultaneous clear.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_op_q <= head[3:0];
            host_q   <= head;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (busy) begin
            wcnt_q  <= '0;
            state_q <= S_EXEC;
          end else if (tmo_hit) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_EXEC: begin
          if (busy) begin
            if (words_left) begin
              wcnt_q <= wcnt_q + WW'(1);
            end
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready        = ~full;
  assign host_instruction = host_q;
  assign done             = done_q;
  assign err              = err_q;
  assign cur_op           = cur_op_q;
  // Strobes follow busy in the same cycle so every busy cycle moves a word.
  assign load_rd   = (state_q == S_EXEC) & busy & is_load   & words_left;
  assign unload_wr = (state_q == S_EXEC) & busy & is_unload & words_left;

endmodule

// File: tb/tb_mpu_host_issuer.sv
// Testbench for mpu_host_issuer: a cycle-stepped controller model drives busy
// for each issued command according to a per-command plan (delay before busy
// rises, number of working busy cycles), and a transaction-level reference
// predicts issue order, completion cycle, strobe counts and the err flag.
module tb_mpu_host_issuer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned WORDS      = 64;
  localparam int unsigned TIMEOUT    = 15;
  localparam int          NEVER      = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic [7:0] host_instruction;
  logic       load_rd;
  logic       unload_wr;
  logic       done;
  logic       err;
  logic [3:0] cur_op;
  logic       err_clr;

  mpu_host_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WORDS     (WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .busy            (busy),
    .host_instruction(host_instruction),
    .load_rd         (load_rd),
    .unload_wr       (unload_wr),
    .done            (done),
    .err             (err),
    .cur_op          (cur_op),
    .err_clr         (err_clr)
  );

  always #5 clk = ~clk;

  // d: busy-low cycles after issue before busy rises (>= TIMEOUT: never rises)
  // n: working busy cycles once the controller has acknowledged
  typedef struct {
    logic [7:0] ins;
    int         d;
    int         n;
  } cmd_t;

  cmd_t pend_q[$];
  cmd_t exp_q[$];
  cmd_t cur;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         inflight = 1'b0;
  int         issue_cyc = 0;
  int         done_cyc = 0;
  int         lcnt = 0;
  int         ucnt = 0;
  int         last_done = -100;
  int         dones = 0;
  bit         err_m = 1'b0;
  logic [3:0] last_op = 4'h0;
  bit         idle_busy = 1'b0;
  int         push_pct = 100;
  int         clr_pct = 0;
  bit         clr_at_set = 1'b0;
  bit         force_clr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_nop(input logic [3:0] op);
    return !(op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF});
  endfunction

  function automatic bit is_xfer(input logic [3:0] op);
    return (op == 4'h4) || (op == 4'h6);
  endfunction

  function automatic bit timed_out(input cmd_t c);
    return c.d >= int'(TIMEOUT);
  endfunction

  function automatic int moved(input cmd_t c);
    if (timed_out(c) || !is_xfer(c.ins[3:0])) return 0;
    return (c.n < int'(WORDS)) ? c.n : int'(WORDS);
  endfunction

  function automatic bit cmd_fails(input cmd_t c);
    if (timed_out(c)) return 1'b1;
    return is_xfer(c.ins[3:0]) && (c.n < int'(WORDS));
  endfunction

  // Cycles from the issue cycle to the done cycle.
  function automatic int duration(input cmd_t c);
    return timed_out(c) ? int'(TIMEOUT) + 1 : c.d + c.n + 3;
  endfunction

  task automatic add(input logic [7:0] ins, input int d, input int n);
    cmd_t c;
    c.ins = ins;
    c.d   = d;
    c.n   = n;
    pend_q.push_back(c);
  endtask

  task automatic observe();
    bit   set_now;
    cmd_t c;
    check("err", 32'(err), 32'(err_m));
    if (host_instruction !== 8'h00) begin
      if (inflight || exp_q.size() == 0) begin
        check("host_unexpected", 32'(host_instruction), 32'h0);
      end else begin
        cur = exp_q.pop_front();
        check("host_ins", 32'(host_instruction), 32'(cur.ins));
        check("issue_gap", 32'((cyc - last_done) >= 2), 32'd1);
        inflight  = 1'b1;
        issue_cyc = cyc;
        done_cyc  = cyc + duration(cur);
        lcnt      = 0;
        ucnt      = 0;
        last_op   = cur.ins[3:0];
      end
    end
    check("cur_op", 32'(cur_op), 32'(last_op));
    if (load_rd !== 1'b0) begin
      if (inflight) lcnt++;
      else check("load_idle", 32'(load_rd), 32'h0);
    end
    if (unload_wr !== 1'b0) begin
      if (inflight) ucnt++;
      else check("unload_idle", 32'(unload_wr), 32'h0);
    end
    check("done", 32'(done), 32'(inflight && cyc == done_cyc));
    set_now = inflight && (cyc == done_cyc - 1) && cmd_fails(cur);
    if (inflight && cyc == done_cyc) begin
      check("n_load", 32'(lcnt), 32'((cur.ins[3:0] == 4'h4) ? moved(cur) : 0));
      check("n_unload", 32'(ucnt), 32'((cur.ins[3:0] == 4'h6) ? moved(cur) : 0));
      inflight  = 1'b0;
      last_done = cyc;
      dones++;
    end
    err_m = set_now || (err_m && !err_clr);
    if (cmd_valid && cmd_ready) begin
      c = pend_q.pop_front();
      if (!is_nop(c.ins[3:0])) exp_q.push_back(c);
    end
  endtask

  task automatic step();
    int k;
    @(posedge clk);
    cyc++;
    #1;
    if (inflight) begin
      k    = cyc - issue_cyc;
      busy = !timed_out(cur) && (k >= cur.d + 1) && (k <= cur.d + 1 + cur.n);
    end else begin
      busy = idle_busy;
    end
    if (pend_q.size() > 0 && int'($urandom_range(99)) < push_pct) begin
      cmd_valid = 1'b1;
      cmd_data  = pend_q[0].ins;
    end else begin
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
    end
    err_clr = force_clr || (clr_at_set && inflight && cyc == done_cyc - 1) ||
              (int'($urandom_range(99)) < clr_pct);
    #4;
    observe();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0 || inflight) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(pend_q.size() + exp_q.size() + int'(inflight)), 32'h0);
    repeat (3) step();
  endtask

  task automatic clear_err();
    force_clr = 1'b1;
    step();
    force_clr = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_host", 32'(host_instruction), 32'h0);
    check("rst_load_rd", 32'(load_rd), 32'h0);
    check("rst_unload_wr", 32'(unload_wr), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_cur_op", 32'(cur_op), 32'h0);
  endtask

  initial begin
    int   n;
    int   d0;
    int   r;
    cmd_t c;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    busy      = 1'b0;
    err_clr   = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ADD, single busy cycle
    add(8'h1C, 0, 0);
    drain("drain_add", 50);
    check("add_err", 32'(err), 32'h0);

    // LOAD full and short transfers
    add(8'h84, 0, 64);
    drain("drain_load64", 200);
    check("load64_err", 32'(err), 32'h0);
    add(8'h84, 0, 63);
    drain("drain_load63", 200);
    check("load63_err", 32'(err), 32'd1);
    clear_err();
    check("err_cleared", 32'(err), 32'h0);

    // UNLOAD with busy never rising: timeout
    add(8'h46, NEVER, 0);
    drain("drain_unload_to", 60);
    check("unload_to_err", 32'(err), 32'd1);
    clear_err();

    // Timeout boundary: one cycle short of the limit, then exactly the limit
    add(8'h2D, int'(TIMEOUT) - 1, 2);
    drain("drain_tmo_m1", 60);
    check("tmo_m1_err", 32'(err), 32'h0);
    add(8'h3E, int'(TIMEOUT), 0);
    drain("drain_tmo_eq", 60);
    check("tmo_eq_err", 32'(err), 32'd1);
    clear_err();

    // Word counter saturates on an over-long UNLOAD
    add(8'h06, 2, 70);
    drain("drain_unload_sat", 200);
    check("unload_sat_err", 32'(err), 32'h0);

    // err_clr in the same cycle as a new error: error wins
    clr_at_set = 1'b1;
    add(8'h47, NEVER, 0);
    drain("drain_collide", 60);
    check("collide_err", 32'(err), 32'd1);
    // err_clr alongside a clean completion clears the flag
    add(8'h1F, 0, 0);
    drain("drain_clean_clr", 60);
    clr_at_set = 1'b0;
    check("clean_clr_err", 32'(err), 32'h0);

    // NOPs are discarded silently
    d0 = dones;
    add(8'h00, 0, 0);
    add(8'h01, 0, 0);
    add(8'h47, 0, 3);
    drain("drain_nop", 80);
    check("nop_dones", 32'(dones - d0), 32'd1);

    // Queue fills while the controller is held busy, then drains in order
    idle_busy = 1'b1;
    add(8'h1C, 0, 1);
    add(8'h2D, 1, 0);
    add(8'hB5, 0, 2);
    add(8'h4E, 0, 0);
    add(8'h9F, 0, 1);
    repeat (8) step();
    check("full_ready", 32'(cmd_ready), 32'h0);
    check("full_accepted", 32'(5 - pend_q.size()), 32'd4);
    idle_busy = 1'b0;
    drain("drain_full", 200);

    // Reset in the middle of a LOAD with more commands queued behind it
    add(8'h84, 0, 100);
    add(8'h1C, 0, 0);
    add(8'h47, 0, 0);
    n = 0;
    while (!(inflight && lcnt == 30) && n < 300) begin
      step();
      n++;
    end
    check("reached_word30", 32'(lcnt), 32'd30);
    #1;
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check_reset_outputs();
    pend_q.delete();
    exp_q.delete();
    inflight  = 1'b0;
    err_m     = 1'b0;
    last_op   = 4'h0;
    last_done = -100;
    busy      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) step();

    // Randomised command stream
    push_pct = 60;
    clr_pct  = 5;
    for (int i = 0; i < 40; i++) begin
      c.ins = 8'($urandom);
      r = int'($urandom_range(9));
      if (r < 6)       c.d = int'($urandom_range(3));
      else if (r == 6) c.d = int'(TIMEOUT) - 1;
      else if (r == 7) c.d = int'(TIMEOUT);
      else if (r == 8) c.d = NEVER;
      else             c.d = int'($urandom_range(12, 4));
      if (is_xfer(c.ins[3:0])) begin
        r = int'($urandom_range(3));
        if (r == 0)      c.n = int'(WORDS) - 1;
        else if (r == 1) c.n = int'(WORDS);
        else if (r == 2) c.n = int'(WORDS) + 3;
        else             c.n = int'($urandom_range(5));
      end else begin
        c.n = int'($urandom_range(4));
      end
      pend_q.push_back(c);
    end
    drain("drain_random", 8000);
    push_pct = 100;
    clr_pct  = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
